// File: rtl/fir_mac_secuenciador_if.sv
// Sample/coefficient/result bundle between the FIR sequencer and its surroundings.
// master: sample source, coefficient ROM and result sink side.
// slave: the FIR sequencer itself.
interface fir_mac_secuenciador_if #(
  parameter int N    = 16,
  parameter int TAPS = 8
);
  localparam int KW = $clog2(TAPS);

  logic          muestra_valida;
  logic [N-1:0]  muestra;
  logic [KW-1:0] coef_dir;
  logic [N-1:0]  coef;
  logic [N-1:0]  resultado;
  logic          resultado_valido;
  logic          ocupado;
  logic          desborde;
  logic          perdida;

  modport master (
    output muestra_valida, muestra, coef,
    input  coef_dir, resultado, resultado_valido, ocupado, desborde, perdida
  );

  modport slave (
    input  muestra_valida, muestra, coef,
    output coef_dir, resultado, resultado_valido, ocupado, desborde, perdida
  );
endinterface

// File: rtl/fir_mac_secuenciador.sv
// Time-multiplexed FIR: one N x N multiplier and one accumulator walk TAPS coefficients.
// Latency: resultado_valido TAPS+1 clocks after the accepting edge; min sample period TAPS+2.
// No backpressure: samples arriving while busy are dropped and flagged on perdida.
module fir_mac_secuenciador #(
  parameter int N     = 16,
  parameter int F     = 8,
  parameter int TAPS  = 8,
  parameter int GUARD = 4
) (
  input logic                    clk,
  input logic                    reset,
  fir_mac_secuenciador_if.slave  bus
);
  localparam int KW = $clog2(TAPS);
  localparam int AW = 2*N + GUARD;

  localparam logic [KW-1:0]        K_LAST = KW'(TAPS-1);
  // TAPS reduced modulo 2^KW; adding it realigns a negative ptr-k into 0..TAPS-1.
  localparam logic [KW-1:0]        K_TAPS = KW'(TAPS);
  localparam logic signed [AW-1:0] S_MAX  = AW'((2**(N-1)) - 1);
  localparam logic signed [AW-1:0] S_MIN  = ~S_MAX;

  typedef enum logic [1:0] {IDLE, MAC, SALIDA} state_t;

  state_t                state;
  logic [N-1:0]          buffer [TAPS];
  logic [KW-1:0]         ptr;
  logic [KW-1:0]         k;
  logic signed [AW-1:0]  acc;
  logic [N-1:0]          resultado;
  logic                  resultado_valido;
  logic                  ocupado;
  logic                  desborde;
  logic                  perdida;

  logic [KW-1:0]         idx;
  logic signed [2*N-1:0] prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  s;
  logic [N-1:0]          sat_res;
  logic                  sat_flag;

  // k is parked at 0 outside MAC, so the ROM address is simply k.
  assign bus.coef_dir         = k;
  assign bus.resultado        = resultado;
  assign bus.resultado_valido = resultado_valido;
  assign bus.ocupado          = ocupado;
  assign bus.desborde         = desborde;
  assign bus.perdida          = perdida;

  // Tap index into the circular delay line and the full-precision product.
  always_comb begin
    idx      = (ptr >= k) ? (ptr - k) : (ptr - k + K_TAPS);
    prod     = (2*N)'($signed(bus.coef)) * (2*N)'($signed(buffer[idx]));
    prod_ext = {{GUARD{prod[2*N-1]}}, prod};
  end

  // Truncate toward minus infinity, then clamp to the N-bit signed range.
  always_comb begin
    s        = acc >>> F;
    sat_res  = s[N-1:0];
    sat_flag = 1'b0;
    if (s > S_MAX) begin
      sat_res  = S_MAX[N-1:0];
      sat_flag = 1'b1;
    end else if (s < S_MIN) begin
      sat_res  = S_MIN[N-1:0];
      sat_flag = 1'b1;
    end
  end

  // Sequencer FSM with delay line, accumulator and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= '0;
      k                <= '0;
      acc              <= '0;
      resultado        <= '0;
      resultado_valido <= 1'b0;
      ocupado          <= 1'b0;
      desborde         <= 1'b0;
      perdida          <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        buffer[i] <= '0;
      end
    end else begin
      resultado_valido <= 1'b0;
      desborde         <= 1'b0;
      perdida          <= bus.muestra_valida && (state != IDLE);
      case (state)
        IDLE: begin
          if (bus.muestra_valida) begin
            buffer[ptr] <= bus.muestra;
            acc         <= '0;
            k           <= '0;
            ocupado     <= 1'b1;
            state       <= MAC;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          if (k == K_LAST) begin
            k     <= '0;
            state <= SALIDA;
          end else begin
            k <= k + KW'(1);
          end
        end
        SALIDA: begin
          resultado        <= sat_res;
          resultado_valido <= 1'b1;
          desborde         <= sat_flag;
          ptr              <= (ptr == K_LAST) ? '0 : ptr + KW'(1);
          ocupado          <= 1'b0;
          state            <= IDLE;
        end
        default: begin
          ocupado <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_secuenciador.sv
// Directed bench for fir_mac_secuenciador: vector table plus hand-written
// sequences for reset, back-to-back drops and reset during MAC.
module tb_fir_mac_secuenciador;
  localparam int N    = 16;
  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic reset;
  int   rom_sel;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  fir_mac_secuenciador_if #(.N(N), .TAPS(TAPS)) bus ();

  fir_mac_secuenciador #(.N(N), .F(8), .TAPS(TAPS), .GUARD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Coefficient ROM: 0 = ramp 0x0100*(k+1), 1 = all 0x7FFF, 2 = only coef[0]=0x0080.
  always_comb begin
    bus.coef = 16'h0000;
    case (rom_sel)
      0:       bus.coef = 16'(256 * (int'(bus.coef_dir) + 1));
      1:       bus.coef = 16'h7FFF;
      default: bus.coef = (bus.coef_dir == '0) ? 16'h0080 : 16'h0000;
    endcase
  end

  typedef struct {
    int          rom;
    logic [15:0] muestra;
    logic [15:0] res;
    logic        desb;
  } vec_t;

  vec_t tbl [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One sample: pulse muestra_valida, follow the MAC sweep, check latency and result.
  task automatic send(input vec_t v, input int id);
    int lat;
    bit got;
    rom_sel = v.rom;
    @(negedge clk);
    bus.muestra        = v.muestra;
    bus.muestra_valida = 1'b1;
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    chk($sformatf("v%0d ocupado", id), 32'(bus.ocupado), 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      if (lat == 3)
        chk($sformatf("v%0d coef_dir", id), 32'(bus.coef_dir), 32'd3);
      @(negedge clk);
      lat++;
      if (bus.resultado_valido) got = 1'b1;
    end
    chk($sformatf("v%0d latency", id), 32'(lat), 32'd9);
    chk($sformatf("v%0d resultado", id), 32'(bus.resultado), 32'(v.res));
    chk($sformatf("v%0d desborde", id), 32'(bus.desborde), 32'(v.desb));
    @(negedge clk);
    chk($sformatf("v%0d pulse", id), 32'(bus.resultado_valido), 32'd0);
    chk($sformatf("v%0d hold", id), 32'(bus.resultado), 32'(v.res));
  endtask

  initial begin
    logic [15:0] neg_res [8];
    logic        neg_dsb [8];
    int          rv_seen;
    vec_t        imp;

    neg_res = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hFE00,
                16'h8000, 16'h8000, 16'h8000, 16'h8000};
    neg_dsb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      tbl[i]      = '{0, (i == 0) ? 16'h0100 : 16'h0000, 16'(256 * (i + 1)), 1'b0};
      tbl[8 + i]  = '{1, 16'h7FFF, 16'h7FFF, 1'b1};
      tbl[16 + i] = '{1, 16'h8000, neg_res[i], neg_dsb[i]};
    end
    tbl[24] = '{2, 16'hFFFF, 16'hFFFF, 1'b0};
    tbl[25] = '{2, 16'h0001, 16'h0000, 1'b0};
    tbl[26] = '{2, 16'h0300, 16'h0180, 1'b0};
    tbl[27] = '{2, 16'h8000, 16'hC000, 1'b0};
    tbl[28] = '{2, 16'hFF00, 16'hFF80, 1'b0};

    // Reset state.
    rom_sel            = 0;
    reset              = 1'b1;
    bus.muestra_valida = 1'b0;
    bus.muestra        = '0;
    repeat (2) @(negedge clk);
    chk("rst resultado", 32'(bus.resultado), 32'd0);
    chk("rst valido", 32'(bus.resultado_valido), 32'd0);
    chk("rst ocupado", 32'(bus.ocupado), 32'd0);
    chk("rst desborde", 32'(bus.desborde), 32'd0);
    chk("rst perdida", 32'(bus.perdida), 32'd0);
    chk("rst coef_dir", 32'(bus.coef_dir), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Impulse, saturation and truncation vectors.
    for (int i = 0; i < 29; i++) send(tbl[i], i);

    // Continuous muestra_valida: acceptance every 10 cycles, drops in between.
    rom_sel = 0;
    @(negedge clk);
    bus.muestra        = 16'h0100;
    bus.muestra_valida = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      chk($sformatf("b2b t%0d ocupado", t), 32'(bus.ocupado), 32'((t % 10) != 0));
      chk($sformatf("b2b t%0d perdida", t), 32'(bus.perdida), 32'((t % 10) != 1));
      chk($sformatf("b2b t%0d valido", t), 32'(bus.resultado_valido), 32'((t % 10) == 0));
    end
    bus.muestra_valida = 1'b0;
    @(negedge clk);
    chk("b2b perdida end", 32'(bus.perdida), 32'd0);
    chk("b2b ocupado end", 32'(bus.ocupado), 32'd0);

    // Reset while MAC is at k=4.
    @(negedge clk);
    bus.muestra        = 16'h0300;
    bus.muestra_valida = 1'b1;
    @(negedge clk);
    bus.muestra_valida = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid k", 32'(bus.coef_dir), 32'd4);
    reset = 1'b1;
    #1;
    chk("mid resultado", 32'(bus.resultado), 32'd0);
    chk("mid ocupado", 32'(bus.ocupado), 32'd0);
    chk("mid coef_dir", 32'(bus.coef_dir), 32'd0);
    chk("mid valido", 32'(bus.resultado_valido), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    rv_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.resultado_valido) rv_seen++;
    end
    chk("mid no valido", 32'(rv_seen), 32'd0);
    imp = '{0, 16'h0100, 16'h0100, 1'b0};
    send(imp, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
